// File: rtl/bcd_pkg.sv
// Shared constants and types for the serial binary-to-BCD converter.
// Holds the digit width, the add-3 threshold and the FSM state type.
package bcd_pkg;
  localparam int         DIG_W   = 4;
  localparam logic [3:0] ADD3_TH = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq.
// master: start, bin out; busy, done, bcd, ovf in. slave: reverse.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit's add-3 correction applied before each shift.
// dig_i: raw scratch digit; dig_o: digit + 3 when >= 5, else unchanged.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] dig_i,
  output logic [DIG_W-1:0] dig_o
);
  assign dig_o = (dig_i >= ADD3_TH) ? dig_i + 4'd3 : dig_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter, one bit per clock, MSB first.
// Ports: clk_i, rst_ni, start_i, bin_i in; busy_o, done_o, bcd_o, ovf_o out.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);
  localparam int BW = DIG_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             oacc_q, oacc_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    shf;
  logic [BW-1:0]    nines;
  logic             last;
  logic             ovf_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .dig_i (scr_q[g*DIG_W +: DIG_W]),
      .dig_o (adj[g*DIG_W +: DIG_W])
    );
    assign nines[g*DIG_W +: DIG_W] = 4'd9;
  end

  // The adjusted top bit falls off the register on the shift;
  // any such bit means the value needs more digits.
  assign shf  = {adj[BW-2:0], bin_q[BIN_W-1]};
  assign last = (cnt_q == CW'(BIN_W - 1));
  assign ovf_nxt = oacc_q | adj[BW-1]
                 | (shf[BW-1 -: DIG_W] > 4'd9);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      oacc_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      oacc_q  <= oacc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    oacc_d  = oacc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          state_d = SHIFT;
          bin_d   = bin_i;
          scr_d   = '0;
          cnt_d   = '0;
          oacc_d  = 1'b0;
        end
      end
      SHIFT: begin
        scr_d  = shf;
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        oacc_d = ovf_nxt;
        if (last) begin
          state_d = DONE;
          bcd_d   = ovf_nxt ? nines : shf;
          ovf_d   = ovf_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == SHIFT);
  assign done_o = (state_q == DONE);
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: default and DIGITS=2 instances.
// Stimulus pushes expected results; per-instance monitors pop and compare.
module tb_bin_to_bcd_seq;
  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if1 ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if2 ();

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (if1.start),
    .bin_i   (if1.bin),
    .busy_o  (if1.busy),
    .done_o  (if1.done),
    .bcd_o   (if1.bcd),
    .ovf_o   (if1.ovf)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (if2.start),
    .bin_i   (if2.bin),
    .busy_o  (if2.busy),
    .done_o  (if2.done),
    .bcd_o   (if2.bcd),
    .ovf_o   (if2.ovf)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic done_of(int sel);
    return (sel == 1) ? if1.done : if2.done;
  endfunction

  task automatic drive(int sel, logic s, logic [7:0] b);
    if (sel == 1) begin
      if1.start = s;
      if1.bin   = b;
    end else begin
      if2.start = s;
      if2.bin   = b;
    end
  endtask

  task automatic push(int sel, logic [11:0] b, logic o);
    exp_t e;
    e.bcd = b;
    e.ovf = o;
    if (sel == 1) q1.push_back(e);
    else          q2.push_back(e);
  endtask

  // Edges counted after the call until done is seen; -1 on timeout.
  task automatic wait_done(int sel, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = done_of(sel);
    end
    if (!seen) n = -1;
  endtask

  task automatic convert(int sel, logic [7:0] v,
                         logic [11:0] eb, logic eo);
    int n;
    push(sel, eb, eo);
    @(negedge clk);
    drive(sel, 1'b1, v);
    @(negedge clk);
    drive(sel, 1'b0, v);
    wait_done(sel, n);
    check("latency", n + 1, 9);
  endtask

  // Monitors: compare on done, check bcd holds while busy.
  logic [11:0] last1, last2;
  int run1, run2;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      last1 = '0;
      run1  = 0;
    end else begin
      if (if1.busy) begin
        run1++;
        check("hold1", {20'd0, if1.bcd}, {20'd0, last1});
      end
      if (if1.done) begin
        if (q1.size() == 0) begin
          check("unexpected_done1", 1, 0);
        end else begin
          e = q1.pop_front();
          check("bcd1", {20'd0, if1.bcd}, {20'd0, e.bcd});
          check("ovf1", {31'd0, if1.ovf}, {31'd0, e.ovf});
          check("busy_len1", run1, 8);
          last1 = e.bcd;
        end
        run1 = 0;
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      last2 = '0;
      run2  = 0;
    end else begin
      if (if2.busy) begin
        run2++;
        check("hold2", {24'd0, if2.bcd}, {20'd0, last2});
      end
      if (if2.done) begin
        if (q2.size() == 0) begin
          check("unexpected_done2", 1, 0);
        end else begin
          e = q2.pop_front();
          check("bcd2", {24'd0, if2.bcd}, {20'd0, e.bcd});
          check("ovf2", {31'd0, if2.ovf}, {31'd0, e.ovf});
          check("busy_len2", run2, 8);
          last2 = e.bcd;
        end
        run2 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(1, 1'b0, 8'd0);
    drive(2, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    check("rst_busy1", {31'd0, if1.busy}, 0);
    check("rst_done1", {31'd0, if1.done}, 0);
    check("rst_bcd1", {20'd0, if1.bcd}, 0);
    check("rst_ovf1", {31'd0, if1.ovf}, 0);
    check("rst_bcd2", {24'd0, if2.bcd}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(2, 8'd99,  12'h099, 1'b0);
    convert(2, 8'd100, 12'h099, 1'b1);
    convert(2, 8'd73,  12'h073, 1'b0);

    convert(1, 8'd0,   12'h000, 1'b0);
    convert(1, 8'd255, 12'h255, 1'b0);
    convert(1, 8'd42,  12'h042, 1'b0);

    // Mid-conversion input change and start re-pulse are ignored.
    push(1, 12'h015, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 8'd15);
    @(negedge clk);
    drive(1, 1'b0, 8'd15);
    repeat (2) @(negedge clk);
    drive(1, 1'b1, 8'd99);
    @(negedge clk);
    drive(1, 1'b0, 8'd99);
    wait_done(1, n);
    check("done15_seen", {31'd0, n >= 0}, 1);
    repeat (14) @(negedge clk);

    // Reset in the 4th SHIFT cycle aborts without done.
    @(negedge clk);
    drive(1, 1'b1, 8'd99);
    @(negedge clk);
    drive(1, 1'b0, 8'd99);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, if1.busy}, 0);
    check("abort_done", {31'd0, if1.done}, 0);
    check("abort_bcd", {20'd0, if1.bcd}, 0);
    check("abort_ovf", {31'd0, if1.ovf}, 0);
    repeat (3) @(negedge clk);
    check("abort_idle", {31'd0, if1.done | if1.busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    convert(1, 8'd5, 12'h005, 1'b0);

    // Back-to-back with start held high.
    push(1, 12'h005, 1'b0);
    push(1, 12'h073, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 8'd5);
    @(negedge clk);
    drive(1, 1'b1, 8'd73);
    wait_done(1, n);
    check("b2b_lat1", n + 1, 9);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 8'd73);
    wait_done(1, n);
    check("b2b_period", n + 1, 9);

    repeat (20) @(negedge clk);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL provide parameter BIN_W, default 8, binary input width (legal range 4..16).
REQ-002 SHALL provide parameter DIGITS, default 3, number of BCD output digits (legal range 1..5).
REQ-003 SHALL provide port clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL provide port start_i  input  1  conversion request; sampled only when busy_o is low.
REQ-006 SHALL provide port bin_i  input  BIN_W  unsigned binary value, captured on an accepted start_i.
REQ-007 SHALL provide port busy_o  output  1  high while a conversion is in progress.
REQ-008 SHALL provide port done_o  output  1  one-cycle pulse marking new valid result.
REQ-009 SHALL provide port bcd_o  output  4*DIGITS  packed BCD result; digit 0 (ones) in bits [3:0], tens in [7:4], and so on.
REQ-010 SHALL provide port ovf_o  output  1  result exceeded 10^DIGITS-1; valid alongside bcd_o.

Function
REQ-011 SHALL implement an iterative shift-add-3 (double-dabble) conversion: one bit per clock, MSB first.
REQ-012 SHALL use three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: busy_o=0, done_o=0; start_i=1 at an edge -> capture bin_i, clear the scratch BCD register, clear the bit counter, go to SHIFT.
REQ-014 SHIFT: each edge applies add-3 to every scratch digit >=5, then shifts left one bit; after exactly BIN_W steps -> DONE.
REQ-015 busy_o SHALL be high for exactly BIN_W cycles, starting the cycle after start_i is accepted.
REQ-016 DONE: lasts exactly one cycle; done_o=1; bcd_o/ovf_o updated on entry; next edge -> IDLE.
REQ-017 Latency SHALL be fixed: done_o high in the cycle following the (BIN_W+1)-th... counted as BIN_W+1 edges after the accepting edge, independent of the value.
REQ-018 start_i in DONE SHALL be accepted exactly as in IDLE (back-to-back conversions, one DONE cycle between them).
REQ-019 start_i during SHIFT SHALL be ignored; bin_i changes during SHIFT SHALL not affect the result.
REQ-020 bcd_o and ovf_o SHALL hold their last result until the next DONE entry; they SHALL not change during SHIFT.
REQ-021 Overflow: if any 1 bit is shifted out of the top digit, or the top digit exceeds 9, ovf_o=1 and bcd_o SHALL saturate to all digits = 9.
REQ-022 With no overflow, every bcd_o digit SHALL be 0..9 and equal the decimal digits of the captured value, with leading zeros present.

Reset
REQ-023 rst_ni low SHALL immediately force state=IDLE, busy_o=0, done_o=0, bcd_o=0, ovf_o=0, bit counter=0, scratch register=0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the conversion with no done_o pulse; start_i SHALL not be accepted until the first edge after rst_ni rises.

Structure
REQ-025 Shared package bcd_pkg SHALL hold: the BCD digit width constant (4), the add-3 threshold constant (5), and the state enum type (IDLE/SHIFT/DONE).
REQ-026 A sub-module bcd_digit_adj SHALL implement one digit's add-3 correction, instantiated DIGITS times through a generate loop.
REQ-027 The bit counter SHALL be $clog2(BIN_W+1) bits wide.

Verification
REQ-028 Defaults; bin_i=0, start pulse -> done_o after BIN_W+1 edges, bcd_o=0x000, ovf_o=0, busy_o high exactly 8 cycles.
REQ-029 Defaults; bin_i=255 -> bcd_o=0x255, ovf_o=0; bin_i=42 -> bcd_o=0x042.
REQ-030 DIGITS=2; bin_i=99 -> bcd_o=0x99, ovf_o=0; bin_i=100 -> bcd_o=0x99, ovf_o=1; bin_i=73 -> bcd_o=0x73, ovf_o=0.
REQ-031 Defaults; start bin_i=15, then during SHIFT change bin_i to 99 and re-pulse start_i -> result 0x015, only one done_o pulse.
REQ-032 Defaults; start bin_i=99, assert rst_ni low at the 4th SHIFT cycle -> outputs zero immediately, no done_o; after release a conversion of 5 yields 0x005.
REQ-033 Back-to-back: start held high continuously with bin_i=5 then 73 -> done_o pulses every BIN_W+1 cycles; results 0x005, then 0x073.
